// File: rtl/rom_seq_reader.sv
// Walks a run of ROM addresses and streams each byte out on valid/ready.
// Optional running byte sum on output checksum when ROM_SEQ_CHECKSUM_EN is defined.
module rom_seq_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
`ifdef ROM_SEQ_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_HOLD,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              hs;
  logic              accept;

  assign hs     = out_valid_q && out_ready;
  assign accept = (state_q == S_IDLE) && start;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remain_d    = remain_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            cur_addr_d = start_addr;
            remain_d   = len;
            state_d    = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        out_data_d  = rom_data;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (hs) begin
          out_valid_d = 1'b0;
          remain_d    = remain_q - 1'b1;
          cur_addr_d  = cur_addr_q + 1'b1;
          state_d     = (remain_q == 1) ? S_DONE : S_READ;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remain_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remain_q    <= remain_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rom_addr  = cur_addr_q;
  assign rom_rd_en = (state_q == S_READ);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

`ifdef ROM_SEQ_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (accept)
      sum_d = '0;
    else if (hs)
      sum_d = sum_q + out_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign checksum = sum_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_rom_seq_reader.sv
// Randomized and directed bench for rom_seq_reader against a word-queue model.
// Define ROM_SEQ_CHECKSUM_EN to also check the checksum output.
module tb_rom_seq_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] len;
  logic [3:0] rom_addr;
  logic       rom_rd_en;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
`ifdef ROM_SEQ_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  rom_seq_reader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .rom_addr   (rom_addr),
    .rom_rd_en  (rom_rd_en),
    .rom_data   (rom_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
`ifdef ROM_SEQ_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  assign rom_data = rom_rd_en ? {4'hA, rom_addr} : 8'h00;

  int         checks = 0;
  int         fails  = 0;
  int         cyc_n  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         stamp_q[$];
  bit         pending   = 0;
  bit         done_seen = 0;
  bit         prev_done = 0;
  bit         rnd_rdy   = 0;
  logic [7:0] cs_m      = 8'h00;

  task automatic chk(input bit ok, input string nm,
                     input int act, input int req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(posedge clk) cyc_n++;

  // Model: the expected stream is the queue of words a run must deliver.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_rd_en) begin
        if (exp_q.size() == 0)
          chk(0, "spurious_rd", rom_addr, 0);
        else
          chk(rom_addr == exp_q[0][3:0], "rom_addr", rom_addr, exp_q[0][3:0]);
        chk(!out_valid, "rd_while_valid", out_valid, 0);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk(0, "spurious_valid", out_data, 0);
        end else begin
          chk(out_data == exp_q[0], "out_data", out_data, exp_q[0]);
          if (out_ready) begin
            got_q.push_back(out_data);
            stamp_q.push_back(cyc_n);
            cs_m = cs_m + out_data;
            void'(exp_q.pop_front());
          end
        end
      end
      chk(busy == pending, "busy", busy, pending);
      if (done) begin
        chk(exp_q.size() == 0, "done_early", exp_q.size(), 0);
        chk(!prev_done, "done_width", prev_done, 0);
`ifdef ROM_SEQ_CHECKSUM_EN
        chk(checksum == cs_m, "checksum", checksum, cs_m);
`endif
        pending   = 0;
        done_seen = 1;
      end
      prev_done = done;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] a, input logic [4:0] l);
    done_seen  = 0;
    start      = 1'b1;
    start_addr = a;
    len        = l;
    for (int i = 0; i < int'(l); i++)
      exp_q.push_back({4'hA, 4'(a + i)});
    cyc();
    start   = 1'b0;
    pending = 1;
    cs_m    = 8'h00;
  endtask

  task automatic ghost_start(input logic [3:0] a, input logic [4:0] l);
    start      = 1'b1;
    start_addr = a;
    len        = l;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_seen && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(done_seen, "done_timeout", n, 400);
    cyc();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = 4'h0;
    len        = 5'd0;
    out_ready  = 1'b0;
    repeat (3) cyc();
    chk({rom_addr, rom_rd_en, out_data, out_valid, busy, done} == '0,
        "reset_state", {rom_addr, out_data}, 0);
    rst_n = 1'b1;
    cyc();

    // Single read with latency pinning.
    out_ready = 1'b1;
    got_q.delete();
    launch(4'd3, 5'd1);
    @(negedge clk);
    chk(rom_rd_en && !out_valid, "lat_read", {rom_rd_en, out_valid}, 2'b10);
    @(negedge clk);
    chk(out_valid && out_data == 8'hA3, "lat_valid", out_data, 8'hA3);
    wait_done();
    chk(got_q.size() == 1 && got_q[0] == 8'hA3, "single_word",
        got_q.size() ? got_q[0] : 0, 8'hA3);

    // Wrap-around, words two clocks apart.
    got_q.delete();
    stamp_q.delete();
    launch(4'd14, 5'd4);
    wait_done();
    chk(got_q.size() == 4, "wrap_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk(got_q[0] == 8'hAE, "wrap_w0", got_q[0], 8'hAE);
      chk(got_q[1] == 8'hAF, "wrap_w1", got_q[1], 8'hAF);
      chk(got_q[2] == 8'hA0, "wrap_w2", got_q[2], 8'hA0);
      chk(got_q[3] == 8'hA1, "wrap_w3", got_q[3], 8'hA1);
      for (int i = 1; i < 4; i++)
        chk(stamp_q[i] - stamp_q[i-1] == 2, "wrap_spacing",
            stamp_q[i] - stamp_q[i-1], 2);
    end

    // Backpressure on the second word.
    got_q.delete();
    launch(4'd0, 5'd3);
    cyc();
    cyc();
    out_ready = 1'b0;
    repeat (5) begin
      cyc();
      chk(out_valid && out_data == 8'hA1 && !rom_rd_en, "stall_hold",
          {out_valid, rom_rd_en, out_data}, {2'b10, 8'hA1});
    end
    out_ready = 1'b1;
    wait_done();
    chk(got_q.size() == 3 && got_q[1] == 8'hA1 && got_q[2] == 8'hA2,
        "stall_stream", got_q.size(), 3);

    // Zero-length run.
    launch(4'd7, 5'd0);
    @(negedge clk);
    chk(done && !out_valid, "len0_done", {done, out_valid}, 2'b10);
    @(negedge clk);
    chk(!done && !busy, "len0_idle", {done, busy}, 0);
    wait_done();

    // Start while busy is ignored.
    got_q.delete();
    launch(4'd2, 5'd3);
    cyc();
    ghost_start(4'd9, 5'd4);
    wait_done();
    chk(got_q.size() == 3 && got_q[2] == 8'hA4, "busy_start",
        got_q.size() ? got_q[got_q.size()-1] : 0, 8'hA4);

    // Reset in the middle of a run.
    out_ready = 1'b0;
    launch(4'd0, 5'd8);
    cyc();
    rst_n = 1'b0;
    #1;
    chk({rom_addr, rom_rd_en, out_data, out_valid, busy, done} == '0,
        "midrun_reset", {rom_addr, out_data}, 0);
    exp_q.delete();
    pending   = 0;
    prev_done = 0;
    cyc();
    cyc();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    got_q.delete();
    launch(4'd5, 5'd2);
    wait_done();
    chk(got_q.size() == 2 && got_q[0] == 8'hA5 && got_q[1] == 8'hA6,
        "post_reset", got_q.size(), 2);

`ifdef ROM_SEQ_CHECKSUM_EN
    launch(4'd0, 5'd16);
    wait_done();
    cyc();
    chk(checksum == 8'h78, "checksum_full", checksum, 8'h78);
`endif

    // Random runs with random backpressure and ghost starts.
    rnd_rdy = 1;
    for (int r = 0; r < 30; r++) begin
      launch(4'($urandom_range(0, 15)), 5'($urandom_range(0, 16)));
      if ($urandom_range(0, 1) == 1)
        ghost_start(4'($urandom_range(0, 15)), 5'($urandom_range(0, 16)));
      wait_done();
      repeat ($urandom_range(0, 2)) cyc();
    end
    rnd_rdy = 0;
    chk(exp_q.size() == 0, "rand_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
